// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and counter width.
package uart_pkg;

    localparam int UART_CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-to-user bundle; the receiver drives it through the master modport.
// o_Rx_Frame_Err exists only when UART_RX_FRAME_ERR_EN is defined.
interface uart_rx_if;

    logic       o_Rx_DV;
    logic [7:0] o_Rx_Byte;
    logic       o_Rx_Active;
`ifdef UART_RX_FRAME_ERR_EN
    logic       o_Rx_Frame_Err;

    modport master (output o_Rx_DV, output o_Rx_Byte, output o_Rx_Active, output o_Rx_Frame_Err);
    modport slave  (input  o_Rx_DV, input  o_Rx_Byte, input  o_Rx_Active, input  o_Rx_Frame_Err);
`else
    modport master (output o_Rx_DV, output o_Rx_Byte, output o_Rx_Active);
    modport slave  (input  o_Rx_DV, input  o_Rx_Byte, input  o_Rx_Active);
`endif

endinterface

// File: rtl/uart_sync2.sv
// Generic two-flop synchronizer for asynchronous inputs; resets to 1 (idle line level).
module uart_sync2 (
    input  logic i_Clock,
    input  logic i_Rst_n,
    input  logic i_d,
    output logic o_q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = i_d;
        sync_d = meta_q;
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a one-cycle byte-valid strobe.
// Define UART_RX_FRAME_ERR_EN to suppress bad-stop frames and flag them on o_Rx_Frame_Err.
//
//  state   | meaning
//  IDLE    | waiting for the synchronized line to go low
//  START   | counting to mid start bit, then confirming it is still low
//  DATA    | sampling 8 data bits, LSB first, one per bit time
//  STOP    | waiting one bit time, then sampling the stop bit
//  CLEANUP | one cycle that ends the DV / error pulse
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 32'd20833
) (
    input  logic      i_Clock,
    input  logic      i_Rst_n,
    input  logic      i_Rx_Serial,
    uart_rx_if.master rx_if
);

    localparam logic [UART_CNT_W-1:0] HALF_CNT = UART_CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [UART_CNT_W-1:0] FULL_CNT = UART_CNT_W'(CLKS_PER_BIT - 1);

    logic                  rx_sync;
    uart_state_e           state_q, state_d;
    logic [UART_CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]            idx_q, idx_d;
    logic [7:0]            shift_q, shift_d;
    logic [7:0]            byte_q, byte_d;
    logic                  dv_q, dv_d;
    logic                  active_q, active_d;
    logic                  err_q, err_d;

    uart_sync2 u_sync (
        .i_Clock (i_Clock),
        .i_Rst_n (i_Rst_n),
        .i_d     (i_Rx_Serial),
        .o_q     (rx_sync)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        byte_d   = byte_q;
        active_d = active_q;
        dv_d     = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_sync) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d = '0;
                    if (!rx_sync) begin
                        active_d = 1'b1;
                        state_d  = DATA;
                    end else begin
                        state_d  = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + UART_CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q < FULL_CNT) begin
                    cnt_d = cnt_q + UART_CNT_W'(1);
                end else begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_sync;
                    if (idx_q < 3'd7) begin
                        idx_d = idx_q + 3'd1;
                    end else begin
                        idx_d   = '0;
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_q < FULL_CNT) begin
                    cnt_d = cnt_q + UART_CNT_W'(1);
                end else begin
                    cnt_d    = '0;
                    active_d = 1'b0;
                    state_d  = CLEANUP;
`ifdef UART_RX_FRAME_ERR_EN
                    if (rx_sync) begin
                        dv_d   = 1'b1;
                        byte_d = shift_q;
                    end else begin
                        err_d  = 1'b1;
                    end
`else
                    dv_d   = 1'b1;
                    byte_d = shift_q;
`endif
                end
            end
            CLEANUP: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                cnt_d    = '0;
                idx_d    = '0;
                active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            byte_q   <= '0;
            dv_q     <= 1'b0;
            active_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            byte_q   <= byte_d;
            dv_q     <= dv_d;
            active_q <= active_d;
            err_q    <= err_d;
        end
    end

    assign rx_if.o_Rx_DV     = dv_q;
    assign rx_if.o_Rx_Byte   = byte_q;
    assign rx_if.o_Rx_Active = active_q;
`ifdef UART_RX_FRAME_ERR_EN
    assign rx_if.o_Rx_Frame_Err = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: two instances (8 and 5 clocks per bit) against a frame-level model.
// Honours UART_RX_FRAME_ERR_EN in the same way as the design.
module tb_uart_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic rx_a  = 1'b1;
    logic rx_b  = 1'b1;

    uart_rx_if if_a ();
    uart_rx_if if_b ();

    uart_rx #(.CLKS_PER_BIT(8)) dut_a (
        .i_Clock     (clk),
        .i_Rst_n     (rst_n),
        .i_Rx_Serial (rx_a),
        .rx_if       (if_a)
    );

    uart_rx #(.CLKS_PER_BIT(5)) dut_b (
        .i_Clock     (clk),
        .i_Rst_n     (rst_n),
        .i_Rx_Serial (rx_b),
        .rx_if       (if_b)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed traffic, sampled on the falling edge.
    logic [7:0] got_a[$];
    logic [7:0] got_b[$];
    int dv_cyc_a   = 0;
    int act_cnt_a  = 0;
    int act_cnt_b  = 0;
    int err_cnt_a  = 0;

    always @(negedge clk) begin
        if (if_a.o_Rx_DV) begin
            got_a.push_back(if_a.o_Rx_Byte);
            dv_cyc_a = cyc;
        end
        if (if_a.o_Rx_Active) act_cnt_a++;
        if (if_b.o_Rx_Active) act_cnt_b++;
`ifdef UART_RX_FRAME_ERR_EN
        if (if_a.o_Rx_Frame_Err) err_cnt_a++;
`endif
        if (if_b.o_Rx_DV) got_b.push_back(if_b.o_Rx_Byte);
    end

    // Reference model: what each completed frame must produce.
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    logic [7:0] last_a = 8'h00;
    logic [7:0] last_b = 8'h00;
    int exp_err_a = 0;
    int fall_cyc_a = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input bit sel, input logic v);
        if (sel) rx_b = v;
        else     rx_a = v;
    endtask

    task automatic send(input bit sel, input logic [7:0] b, input logic stop);
        int cpb;
        cpb = sel ? 5 : 8;
        if (!sel) fall_cyc_a = cyc;
        set_line(sel, 1'b0);
        tick(cpb);
        for (int i = 0; i < 8; i++) begin
            set_line(sel, b[i]);
            tick(cpb);
        end
        set_line(sel, stop);
        tick(cpb);
`ifdef UART_RX_FRAME_ERR_EN
        if (!stop) begin
            if (!sel) exp_err_a++;
        end else if (sel) begin
            exp_b.push_back(b); last_b = b;
        end else begin
            exp_a.push_back(b); last_a = b;
        end
`else
        if (sel) begin
            exp_b.push_back(b); last_b = b;
        end else begin
            exp_a.push_back(b); last_a = b;
        end
`endif
        if (!stop) begin
            set_line(sel, 1'b1);
            tick(2 * cpb);
        end
    endtask

    task automatic clear_a();
        got_a.delete();
        exp_a.delete();
        act_cnt_a = 0;
        err_cnt_a = 0;
        exp_err_a = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        tick(3);
        n_checks++; if (if_a.o_Rx_DV !== 1'b0) $display("FAIL reset_dv got %b want 0", if_a.o_Rx_DV); else n_pass++;
        n_checks++; if (if_a.o_Rx_Byte !== 8'h00) $display("FAIL reset_byte got %h want 00", if_a.o_Rx_Byte); else n_pass++;
        n_checks++; if (if_a.o_Rx_Active !== 1'b0) $display("FAIL reset_active got %b want 0", if_a.o_Rx_Active); else n_pass++;
        n_checks++; if (if_b.o_Rx_Byte !== 8'h00) $display("FAIL reset_byte_b got %h want 00", if_b.o_Rx_Byte); else n_pass++;
`ifdef UART_RX_FRAME_ERR_EN
        n_checks++; if (if_a.o_Rx_Frame_Err !== 1'b0) $display("FAIL reset_ferr got %b want 0", if_a.o_Rx_Frame_Err); else n_pass++;
`endif
        rst_n = 1'b1;
        last_a = 8'h00;
        last_b = 8'h00;
        tick(10);
        n_checks++; if (act_cnt_a != 0) $display("FAIL idle_active got %0d want 0", act_cnt_a); else n_pass++;
        clear_a();
    endtask

    task automatic test_single();
        int lat;
        clear_a();
        send(0, 8'hA5, 1'b1);
        tick(16);
        lat = dv_cyc_a - fall_cyc_a;
        n_checks++; if (got_a.size() != 1) $display("FAIL single_count got %0d want 1", got_a.size()); else n_pass++;
        n_checks++; if (got_a.size() > 0 && got_a[0] !== 8'hA5) $display("FAIL single_byte got %h want a5", got_a[0]); else n_pass++;
        n_checks++; if (lat < 77 || lat > 79) $display("FAIL single_latency got %0d want 77..79", lat); else n_pass++;
        n_checks++; if (act_cnt_a < 68 || act_cnt_a > 80) $display("FAIL single_active got %0d want 68..80", act_cnt_a); else n_pass++;
        tick(40);
        n_checks++; if (if_a.o_Rx_Byte !== last_a) $display("FAIL single_hold got %h want %h", if_a.o_Rx_Byte, last_a); else n_pass++;
    endtask

    task automatic test_back_to_back();
        clear_a();
        send(0, 8'h00, 1'b1);
        send(0, 8'hFF, 1'b1);
        send(0, 8'h55, 1'b1);
        tick(16);
        n_checks++; if (got_a.size() != exp_a.size()) $display("FAIL b2b_count got %0d want %0d", got_a.size(), exp_a.size()); else n_pass++;
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            n_checks++; if (got_a[i] !== exp_a[i]) $display("FAIL b2b_byte%0d got %h want %h", i, got_a[i], exp_a[i]); else n_pass++;
        end
    endtask

    task automatic test_glitch();
        clear_a();
        rx_a = 1'b0;
        tick(3);
        rx_a = 1'b1;
        tick(30);
        n_checks++; if (got_a.size() != 0) $display("FAIL glitch_dv got %0d want 0", got_a.size()); else n_pass++;
        n_checks++; if (act_cnt_a != 0) $display("FAIL glitch_active got %0d want 0", act_cnt_a); else n_pass++;
        send(0, 8'h5A, 1'b1);
        tick(16);
        n_checks++; if (got_a.size() != 1) $display("FAIL glitch_recover_count got %0d want 1", got_a.size()); else n_pass++;
        n_checks++; if (got_a.size() > 0 && got_a[0] !== 8'h5A) $display("FAIL glitch_recover_byte got %h want 5a", got_a[0]); else n_pass++;
    endtask

    task automatic test_frame_err();
        clear_a();
        send(0, 8'h3C, 1'b0);
        tick(24);
        n_checks++; if (got_a.size() != exp_a.size()) $display("FAIL ferr_dv_count got %0d want %0d", got_a.size(), exp_a.size()); else n_pass++;
        n_checks++; if (if_a.o_Rx_Byte !== last_a) $display("FAIL ferr_byte got %h want %h", if_a.o_Rx_Byte, last_a); else n_pass++;
`ifdef UART_RX_FRAME_ERR_EN
        n_checks++; if (err_cnt_a != exp_err_a) $display("FAIL ferr_pulse got %0d want %0d", err_cnt_a, exp_err_a); else n_pass++;
`endif
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        b = 8'h81;
        clear_a();
        rx_a = 1'b0;
        tick(8);
        for (int i = 0; i < 4; i++) begin
            rx_a = b[i];
            tick(8);
        end
        rx_a = b[4];
        tick(3);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        rx_a = 1'b1;
        last_a = 8'h00;
        last_b = 8'h00;
        n_checks++; if (if_a.o_Rx_Byte !== 8'h00) $display("FAIL rstmid_byte got %h want 00", if_a.o_Rx_Byte); else n_pass++;
        n_checks++; if (if_a.o_Rx_Active !== 1'b0) $display("FAIL rstmid_active got %b want 0", if_a.o_Rx_Active); else n_pass++;
        tick(96);
        n_checks++; if (got_a.size() != 0) $display("FAIL rstmid_nodv got %0d want 0", got_a.size()); else n_pass++;
        send(0, 8'h7E, 1'b1);
        tick(16);
        n_checks++; if (got_a.size() != 1) $display("FAIL rstmid_next_count got %0d want 1", got_a.size()); else n_pass++;
        n_checks++; if (got_a.size() > 0 && got_a[0] !== 8'h7E) $display("FAIL rstmid_next_byte got %h want 7e", got_a[0]); else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic       stop;
        clear_a();
        for (int k = 0; k < 10; k++) begin
            b    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            send(0, b, stop);
            tick($urandom_range(0, 20));
        end
        tick(24);
        n_checks++; if (got_a.size() != exp_a.size()) $display("FAIL rand_count got %0d want %0d", got_a.size(), exp_a.size()); else n_pass++;
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            n_checks++; if (got_a[i] !== exp_a[i]) $display("FAIL rand_byte%0d got %h want %h", i, got_a[i], exp_a[i]); else n_pass++;
        end
        n_checks++; if (if_a.o_Rx_Byte !== last_a) $display("FAIL rand_hold got %h want %h", if_a.o_Rx_Byte, last_a); else n_pass++;
`ifdef UART_RX_FRAME_ERR_EN
        n_checks++; if (err_cnt_a != exp_err_a) $display("FAIL rand_ferr got %0d want %0d", err_cnt_a, exp_err_a); else n_pass++;
`endif
    endtask

    task automatic test_cpb5();
        got_b.delete();
        exp_b.delete();
        act_cnt_b = 0;
        for (int k = 0; k < 6; k++) send(1, 8'($urandom_range(0, 255)), 1'b1);
        tick(12);
        n_checks++; if (got_b.size() != exp_b.size()) $display("FAIL cpb5_count got %0d want %0d", got_b.size(), exp_b.size()); else n_pass++;
        for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
            n_checks++; if (got_b[i] !== exp_b[i]) $display("FAIL cpb5_byte%0d got %h want %h", i, got_b[i], exp_b[i]); else n_pass++;
        end
        n_checks++; if (if_b.o_Rx_Byte !== last_b) $display("FAIL cpb5_hold got %h want %h", if_b.o_Rx_Byte, last_b); else n_pass++;
        n_checks++; if (act_cnt_b < 6 * 40 || act_cnt_b > 6 * 50) $display("FAIL cpb5_active got %0d want 240..300", act_cnt_b); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_random();
        test_cpb5();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
